// File: rtl/engine_response_lane_dispatch_pkg.sv
// ------------------------------------------------------------------
// engine_response_lane_dispatch_pkg: packet/FIFO types and dispatch FSM states
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package engine_response_lane_dispatch_pkg;

  localparam int LANE_ID_W = 8;
  localparam logic [1:0] INFLIGHT_LIMIT = 2'd2;
  localparam int RESET_GATE_CYCLES = 2;

  typedef struct packed {
    logic                 valid;
    logic [7:0]           id_cu;
    logic [7:0]           id_bundle;
    logic [LANE_ID_W-1:0] id_lane;
    logic [7:0]           id_engine;
    logic [31:0]          address;
    logic [31:0]          data;
  } MemoryPacket;

  typedef struct packed {
    logic [7:0]           id_cu;
    logic [7:0]           id_bundle;
    logic [LANE_ID_W-1:0] id_lane;
    logic [7:0]           id_engine;
    logic [7:0]           id_module;
  } MemoryPacketArbitrate;

  typedef struct packed {
    logic rd_en;
  } FIFOStateSignalsInput;

  typedef struct packed {
    logic empty;
    logic full;
    logic prog_full;
    logic valid;
  } FIFOStateSignalsOutput;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DRAIN = 2'd2
  } engine_response_dispatch_state_t;

  function automatic logic inflight_room(input logic [1:0] count);
    return count < INFLIGHT_LIMIT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/engine_response_lane_dispatch_inflight_tracker.sv
// ------------------------------------------------------------------
// engine_response_lane_dispatch_inflight_tracker: saturating 2-bit read counter with sticky error
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module engine_response_lane_dispatch_inflight_tracker
  import engine_response_lane_dispatch_pkg::*;
(
  input  logic       ap_clk,
  input  logic       areset_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       err_en,
  output logic [1:0] count,
  output logic       underflow,
  output logic       error
);

  logic overflow;

  assign underflow = dec & (count == 2'd0);
  assign overflow  = inc & ~dec & (count == 2'd3);

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      count <= 2'd0;
      error <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: if (count != 2'd3) count <= count + 2'd1;
        2'b01: if (count != 2'd0) count <= count - 2'd1;
        // A bogus return alongside a real pop: the pop still counts.
        2'b11: if (count == 2'd0) count <= 2'd1;
        default: count <= count;
      endcase
      if (err_en && (underflow || overflow)) error <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/engine_response_lane_dispatch.sv
// ------------------------------------------------------------------
// engine_response_lane_dispatch: pops the engine response FIFO and fans packets out to lanes
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module engine_response_lane_dispatch
  import engine_response_lane_dispatch_pkg::*;
#(
  parameter int ID_CU         = 0,
  parameter int ID_BUNDLE     = 0,
  parameter int ID_LANE       = 0,
  parameter int ID_ENGINE     = 0,
  parameter int ID_MODULE     = 0,
  parameter int NUM_LANES_MAX = 4,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     ap_clk,
  input  logic                     areset_n,
  input  logic                     configure_route_valid,
  input  MemoryPacketArbitrate     configure_route_in,
  input  FIFOStateSignalsInput     fifo_response_engine_in_signals_in,
  input  FIFOStateSignalsOutput    fifo_response_engine_state_in,
  input  MemoryPacket              response_engine_in,
  output FIFOStateSignalsInput     fifo_response_engine_in_signals_out,
  output MemoryPacket              response_lanes_out [NUM_LANES_MAX-1:0],
  output logic [COUNTER_WIDTH-1:0] dispatch_count,
  output logic [COUNTER_WIDTH-1:0] drop_count,
  output logic                     route_active,
  output logic                     protocol_error
);

  engine_response_dispatch_state_t state;
  logic [NUM_LANES_MAX-1:0] active_mask;
  logic [NUM_LANES_MAX-1:0] pending_mask;
  logic [NUM_LANES_MAX-1:0] new_mask;
  logic [1:0]               in_flight;
  logic [1:0]               gate_cnt;
  logic                     err_en;
  logic                     underflow;
  logic                     pop_next;
  logic                     accept;
  logic                     unused_ok;

  assign new_mask = configure_route_in.id_lane[NUM_LANES_MAX-1:0];
  assign err_en   = (gate_cnt == 2'(RESET_GATE_CYCLES));
  assign pop_next = (state == ROUTE) & fifo_response_engine_in_signals_in.rd_en
                  & ~fifo_response_engine_state_in.empty & inflight_room(in_flight)
                  & ~configure_route_valid;
  // Returns with nothing outstanding are discarded, never dispatched.
  assign accept   = response_engine_in.valid & ~underflow;

  assign unused_ok = ^{ID_CU, ID_BUNDLE, ID_LANE, ID_ENGINE, ID_MODULE, configure_route_in,
                       fifo_response_engine_state_in, fifo_response_engine_in_signals_in};

  engine_response_lane_dispatch_inflight_tracker u_inflight (
    .ap_clk    (ap_clk),
    .areset_n  (areset_n),
    .inc       (fifo_response_engine_in_signals_out.rd_en),
    .dec       (response_engine_in.valid),
    .err_en    (err_en),
    .count     (in_flight),
    .underflow (underflow),
    .error     (protocol_error)
  );

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      state                               <= IDLE;
      active_mask                         <= '0;
      pending_mask                        <= '0;
      route_active                        <= 1'b0;
      fifo_response_engine_in_signals_out <= '0;
      gate_cnt                            <= 2'd0;
    end else begin
      if (!err_en) gate_cnt <= gate_cnt + 2'd1;
      fifo_response_engine_in_signals_out.rd_en <= pop_next;
      case (state)
        IDLE: begin
          if (configure_route_valid) begin
            active_mask  <= new_mask;
            state        <= ROUTE;
            route_active <= 1'b1;
          end
        end
        ROUTE: begin
          if (configure_route_valid) begin
            pending_mask <= new_mask;
            state        <= DRAIN;
            route_active <= 1'b0;
          end
        end
        DRAIN: begin
          // The old route stays active until every read issued under it has returned.
          if (in_flight == 2'd0) begin
            active_mask  <= configure_route_valid ? new_mask : pending_mask;
            state        <= ROUTE;
            route_active <= 1'b1;
          end else if (configure_route_valid) begin
            pending_mask <= new_mask;
          end
        end
        default: begin
          state        <= IDLE;
          route_active <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      dispatch_count <= '0;
      drop_count     <= '0;
    end else if (accept) begin
      if (|active_mask) dispatch_count <= dispatch_count + COUNTER_WIDTH'(1);
      else              drop_count     <= drop_count + COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < NUM_LANES_MAX; i++) response_lanes_out[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES_MAX; i++) begin
        response_lanes_out[i]       <= response_engine_in;
        response_lanes_out[i].valid <= accept & active_mask[i];
      end
    end
  end

endmodule

`default_nettype wire
